// File: rtl/ext_bus_sched_if.sv
// CPU port, DMA burst port and peripheral bus of the external-bus scheduler.
// slave = scheduler side, master = CPU/DMA/peripheral side.
interface ext_bus_sched_if #(
  parameter int LEN_W = 9
);
  logic [31:0]      cpu_addr;
  logic             cpu_re;
  logic             cpu_we;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             dma_start;
  logic             dma_wr;
  logic [31:0]      dma_base;
  logic [LEN_W-1:0] dma_len;
  logic [31:0]      dma_wdata;
  logic             dma_wdata_pop;
  logic [31:0]      dma_rdata;
  logic             dma_rvalid;
  logic             dma_busy;
  logic             dma_done;
  logic             dma_starved;
  logic [31:0]      bus_addr;
  logic             bus_re;
  logic             bus_we;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_wdata,
    input  dma_start, dma_wr, dma_base, dma_len, dma_wdata,
    input  bus_rdata,
    output cpu_rdata, dma_wdata_pop, dma_rdata, dma_rvalid,
    output dma_busy, dma_done, dma_starved,
    output bus_addr, bus_re, bus_we, bus_wdata
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_wdata,
    output dma_start, dma_wr, dma_base, dma_len, dma_wdata,
    output bus_rdata,
    input  cpu_rdata, dma_wdata_pop, dma_rdata, dma_rvalid,
    input  dma_busy, dma_done, dma_starved,
    input  bus_addr, bus_re, bus_we, bus_wdata
  );
endinterface

// File: rtl/ext_bus_sched.sv
// Shares the external bus between the CPU (absolute priority, zero-latency combinational path)
// and a burst DMA; DMA beats fill CPU-free cycles, read beats return one cycle later, the CPU never stalls.
module ext_bus_sched #(
  parameter int LEN_W        = 9,
  parameter int STARVE_LIMIT = 64
) (
  input logic              clk,
  input logic              rst_n,
  ext_bus_sched_if.slave   bus_if
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             done_q, done_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;

  logic cpu_ext;
  logic beat;
  logic last_beat;

  assign cpu_ext   = (|bus_if.cpu_addr[31:13]) & (bus_if.cpu_re | bus_if.cpu_we);
  assign beat      = (state_q == BURST) & ~cpu_ext;
  assign last_beat = beat & (idx_q == len_q - LEN_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      starve_q <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      starve_q <= starve_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    starve_d = starve_q;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus_if.dma_start) begin
          base_d   = bus_if.dma_base;
          len_d    = bus_if.dma_len;
          dir_d    = bus_if.dma_wr;
          idx_d    = '0;
          starve_d = '0;
          // A zero-length burst completes without ever entering BURST.
          if (bus_if.dma_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (cpu_ext) begin
          if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
          end
        end else begin
          idx_d    = idx_q + LEN_ONE;
          starve_d = '0;
          if (!dir_q) begin
            rvalid_d = 1'b1;
            rdata_d  = bus_if.bus_rdata;
          end
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_if.bus_addr      = '0;
    bus_if.bus_re        = 1'b0;
    bus_if.bus_we        = 1'b0;
    bus_if.bus_wdata     = '0;
    bus_if.cpu_rdata     = 32'h0000_DEAD;
    bus_if.dma_wdata_pop = 1'b0;
    if (cpu_ext) begin
      bus_if.bus_addr  = bus_if.cpu_addr;
      bus_if.bus_re    = bus_if.cpu_re;
      bus_if.bus_we    = bus_if.cpu_we;
      bus_if.bus_wdata = bus_if.cpu_wdata;
      bus_if.cpu_rdata = bus_if.bus_rdata;
    end else if (beat) begin
      bus_if.bus_addr = base_q + {{(32-LEN_W){1'b0}}, idx_q};
      bus_if.bus_re   = ~dir_q;
      bus_if.bus_we   = dir_q;
      if (dir_q) begin
        bus_if.bus_wdata     = bus_if.dma_wdata;
        bus_if.dma_wdata_pop = 1'b1;
      end
    end
  end

  assign bus_if.dma_busy    = (state_q == BURST);
  assign bus_if.dma_done    = done_q;
  assign bus_if.dma_rvalid  = rvalid_q;
  assign bus_if.dma_rdata   = rdata_q;
  assign bus_if.dma_starved = (starve_q == STARVE_MAX);
endmodule

// File: tb/tb_ext_bus_sched.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a queue-based burst model,
// a negedge monitor pops and compares them against the DUT.
module tb_ext_bus_sched;
  localparam int LEN_W = 9;
  localparam int SL    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ext_bus_sched_if #(.LEN_W(LEN_W)) bif ();

  ext_bus_sched #(.LEN_W(LEN_W), .STARVE_LIMIT(SL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bif)
  );

  typedef struct {
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] cpu_rdata;
    logic [31:0] dma_rdata;
    logic        bus_re;
    logic        bus_we;
    logic        pop;
    logic        busy;
    logic        done;
    logic        rvalid;
    logic        starved;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Reference model: a burst is simply the list of addresses still to be issued.
  logic [31:0] m_beats[$];
  logic        m_dir    = 1'b0;
  logic        m_done   = 1'b0;
  logic        m_rv     = 1'b0;
  logic [31:0] m_rd     = '0;
  int          m_starve = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cyc++;
        chk("bus_addr",      bif.bus_addr,      e.bus_addr);
        chk("bus_wdata",     bif.bus_wdata,     e.bus_wdata);
        chk("bus_re",        32'(bif.bus_re),   32'(e.bus_re));
        chk("bus_we",        32'(bif.bus_we),   32'(e.bus_we));
        chk("cpu_rdata",     bif.cpu_rdata,     e.cpu_rdata);
        chk("dma_wdata_pop", 32'(bif.dma_wdata_pop), 32'(e.pop));
        chk("dma_busy",      32'(bif.dma_busy),    32'(e.busy));
        chk("dma_done",      32'(bif.dma_done),    32'(e.done));
        chk("dma_rvalid",    32'(bif.dma_rvalid),  32'(e.rvalid));
        chk("dma_rdata",     bif.dma_rdata,     e.dma_rdata);
        chk("dma_starved",   32'(bif.dma_starved), 32'(e.starved));
      end
    end
  end

  task automatic idle_in();
    bif.cpu_addr  = '0;
    bif.cpu_re    = 1'b0;
    bif.cpu_we    = 1'b0;
    bif.cpu_wdata = '0;
    bif.dma_start = 1'b0;
    bif.dma_wr    = 1'b0;
    bif.dma_base  = '0;
    bif.dma_len   = '0;
  endtask

  task automatic start(input logic wr, input logic [31:0] base, input int len);
    bif.dma_start = 1'b1;
    bif.dma_wr    = wr;
    bif.dma_base  = base;
    bif.dma_len   = LEN_W'(len);
  endtask

  // Inputs for this cycle are already driven; record expectations, advance the model, advance time.
  task automatic step();
    exp_t e;
    logic ext;
    if (!rst_n) begin
      m_beats.delete();
      m_done = 1'b0; m_rv = 1'b0; m_rd = '0; m_starve = 0;
    end
    ext = (bif.cpu_addr >= 32'h2000) && (bif.cpu_re || bif.cpu_we);
    e.busy      = (m_beats.size() != 0);
    e.done      = m_done;
    e.rvalid    = m_rv;
    e.dma_rdata = m_rd;
    e.starved   = (m_starve == SL);
    e.bus_addr  = '0; e.bus_wdata = '0; e.bus_re = 1'b0; e.bus_we = 1'b0;
    e.pop       = 1'b0;
    e.cpu_rdata = 32'h0000_DEAD;
    if (ext) begin
      e.bus_addr  = bif.cpu_addr;
      e.bus_re    = bif.cpu_re;
      e.bus_we    = bif.cpu_we;
      e.bus_wdata = bif.cpu_wdata;
      e.cpu_rdata = bif.bus_rdata;
    end else if (e.busy) begin
      e.bus_addr  = m_beats[0];
      e.bus_re    = !m_dir;
      e.bus_we    = m_dir;
      e.bus_wdata = m_dir ? bif.dma_wdata : 32'h0;
      e.pop       = m_dir;
    end
    sb.push_back(e);
    if (rst_n) begin
      m_done = 1'b0;
      m_rv   = 1'b0;
      if (e.busy) begin
        if (ext) begin
          m_starve = (m_starve < SL) ? m_starve + 1 : SL;
        end else begin
          m_beats.delete(0);
          m_starve = 0;
          if (!m_dir) begin
            m_rv = 1'b1;
            m_rd = bif.bus_rdata;
          end
          if (m_beats.size() == 0) m_done = 1'b1;
        end
      end else if (bif.dma_start) begin
        m_dir    = bif.dma_wr;
        m_starve = 0;
        if (bif.dma_len == '0) m_done = 1'b1;
        for (int k = 0; k < int'(bif.dma_len); k++) m_beats.push_back(bif.dma_base + 32'(k));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    bif.dma_wdata = '0;
    bif.bus_rdata = '0;
    @(posedge clk); #1;
    step(); step();
    rst_n = 1'b1;

    bif.cpu_addr = 32'h0000_C001; bif.cpu_re = 1'b1; bif.bus_rdata = 32'h1234;
    step(); idle_in();
    bif.cpu_addr = 32'h0000_0100; bif.cpu_re = 1'b1;
    step(); idle_in();

    start(1'b0, 32'h4000, 4); step(); idle_in();
    repeat (6) begin bif.bus_rdata = $urandom; step(); end

    start(1'b1, 32'h8000, 3); step(); idle_in();
    bif.dma_wdata = $urandom; step();
    bif.cpu_addr = 32'hC000; bif.cpu_we = 1'b1; bif.cpu_wdata = $urandom; bif.dma_wdata = $urandom;
    step(); idle_in();
    repeat (4) begin bif.dma_wdata = $urandom; step(); end

    start(1'b0, 32'h5000, 3); step(); idle_in();
    repeat (6) begin bif.cpu_addr = 32'h3000; bif.cpu_re = 1'b1; bif.bus_rdata = $urandom; step(); end
    idle_in();
    repeat (5) begin bif.bus_rdata = $urandom; step(); end

    start(1'b0, 32'h6000, 0); step(); idle_in();
    repeat (2) step();

    start(1'b0, 32'hFFFF_FFFF, 2); step(); idle_in();
    repeat (4) begin bif.bus_rdata = $urandom; step(); end

    start(1'b1, 32'h7000, 8); step(); idle_in();
    step(); step();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 3000; i++) begin
      bif.cpu_re = ($urandom % 3 == 0);
      bif.cpu_we = !bif.cpu_re && ($urandom % 3 == 0);
      case ($urandom % 4)
        0:       bif.cpu_addr = $urandom % 32'h2000;
        1:       bif.cpu_addr = ($urandom % 2) ? 32'h1FFF : 32'h2000;
        default: bif.cpu_addr = $urandom;
      endcase
      bif.cpu_wdata = $urandom;
      bif.dma_start = ($urandom % 6 == 0);
      bif.dma_wr    = $urandom % 2;
      bif.dma_base  = ($urandom % 8 == 0) ? 32'hFFFF_FFFE : $urandom;
      bif.dma_len   = ($urandom % 10 == 0) ? LEN_W'($urandom_range(0, 40))
                                           : LEN_W'($urandom_range(0, 5));
      bif.dma_wdata = $urandom;
      bif.bus_rdata = $urandom;
      step();
    end

    idle_in();
    repeat (3) step();
    repeat (2) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
